canny_stream_fuse: RTL and testbench

- Parametrised output fusion stage at the tail of the Canny pipeline.
- Delays the source pixel stream by a fixed number of clocks so it lines up with the binary edge stream from the thresholding stage.
- Fuses the two streams into one display stream according to a mode.
- The display mode is applied only at frame boundaries, so frames never tear.

---
 rtl/canny_stream_fuse.sv | 170 +++++++++++++++++
 tb/tb_canny_stream_fuse.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/canny_stream_fuse.sv
// rtl/canny_stream_fuse.sv - delays the source stream to line up with the edge stream, then fuses both under a frame-latched mode
// Optional: define CANNY_ALIGN_CHECK_EN to enable the src/edge lag monitor that drives align_err.
module canny_stream_fuse #(
  parameter int PIX_W  = 16,
  parameter int DELAY  = 15,
  parameter int MODE_W = 3
) (
  input  logic              video_clk,
  input  logic              rst_n,
  input  logic              src_hs,
  input  logic              src_vs,
  input  logic              src_de,
  input  logic [PIX_W-1:0]  src_data,
  input  logic              edge_hs,
  input  logic              edge_vs,
  input  logic              edge_de,
  input  logic              edge_bit,
  input  logic [MODE_W-1:0] mode,
  input  logic [PIX_W-1:0]  edge_color,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_de,
  output logic [PIX_W-1:0]  out_data,
  output logic [MODE_W-1:0] active_mode,
  output logic              align_err
);
  localparam int PTR_W  = $clog2(DELAY);
  localparam int FILL_W = $clog2(DELAY + 1);

  logic [PIX_W-1:0]  dly_mem [DELAY];
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fill;
  logic [PIX_W-1:0]  dly_data;
  logic [PIX_W-1:0]  colour;
  logic              edge_vs_q;
  logic              vs_rise;
  logic [MODE_W-1:0] eff_mode;
  logic [PIX_W-1:0]  eff_colour;
  logic              sel_hs, sel_vs, sel_de;
  logic [PIX_W-1:0]  pix;

  // Written every clock, so the slot about to be overwritten is exactly DELAY clocks old.
  always_ff @(posedge video_clk) begin
    dly_mem[wr_ptr] <= src_data;
  end

  assign dly_data = (fill == FILL_W'(DELAY)) ? dly_mem[wr_ptr] : '0;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      wr_ptr <= (wr_ptr == PTR_W'(DELAY - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (fill != FILL_W'(DELAY))
        fill <= fill + FILL_W'(1);
    end
  end

  // The frame-start pixel already uses the newly captured mode so no pixel mixes two modes.
  assign vs_rise    = edge_vs & ~edge_vs_q;
  assign eff_mode   = vs_rise ? mode : active_mode;
  assign eff_colour = vs_rise ? edge_color : colour;

  always_comb begin
    sel_hs = edge_hs;
    sel_vs = edge_vs;
    sel_de = edge_de;
    pix    = '0;
    case (eff_mode)
      MODE_W'(1): pix = edge_bit ? eff_colour : '0;
      MODE_W'(2): pix = edge_bit ? eff_colour : dly_data;
      MODE_W'(3): pix = edge_bit ? dly_data : '0;
      default: begin
        sel_hs = src_hs;
        sel_vs = src_vs;
        sel_de = src_de;
        pix    = src_data;
      end
    endcase
    if (!sel_de)
      pix = '0;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hs      <= 1'b0;
      out_vs      <= 1'b0;
      out_de      <= 1'b0;
      out_data    <= '0;
      active_mode <= '0;
      colour      <= '0;
      edge_vs_q   <= 1'b0;
    end else begin
      out_hs    <= sel_hs;
      out_vs    <= sel_vs;
      out_de    <= sel_de;
      out_data  <= pix;
      edge_vs_q <= edge_vs;
      if (vs_rise) begin
        active_mode <= mode;
        colour      <= edge_color;
      end
    end
  end

`ifdef CANNY_ALIGN_CHECK_EN
  typedef enum logic [1:0] {AC_IDLE, AC_WAIT, AC_COUNT} ac_state_t;

  ac_state_t   ac_state, ac_next;
  logic [10:0] ac_cnt, ac_cnt_next;
  logic        err, err_next;
  logic        src_vs_q, src_de_q, edge_de_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_state  <= AC_IDLE;
      ac_cnt    <= '0;
      err       <= 1'b0;
      src_vs_q  <= 1'b0;
      src_de_q  <= 1'b0;
      edge_de_q <= 1'b0;
    end else begin
      ac_state  <= ac_next;
      ac_cnt    <= ac_cnt_next;
      err       <= err_next;
      src_vs_q  <= src_vs;
      src_de_q  <= src_de;
      edge_de_q <= edge_de;
    end
  end

  // ac_cnt holds the number of clocks since the first src_de rise of the frame.
  always_comb begin
    ac_next     = ac_state;
    ac_cnt_next = ac_cnt;
    err_next    = err;
    if (src_vs && !src_vs_q) begin
      ac_next = AC_WAIT;
    end else begin
      case (ac_state)
        AC_WAIT: begin
          if (src_de && !src_de_q) begin
            ac_next     = AC_COUNT;
            ac_cnt_next = 11'd1;
          end
        end
        AC_COUNT: begin
          if (edge_de && !edge_de_q) begin
            ac_next = AC_IDLE;
            if (ac_cnt != 11'(DELAY))
              err_next = 1'b1;
          end else if (ac_cnt == 11'h7FF) begin
            ac_next  = AC_IDLE;
            err_next = 1'b1;
          end else begin
            ac_cnt_next = ac_cnt + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign align_err = err;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_canny_stream_fuse.sv
// tb/tb_canny_stream_fuse.sv - directed self-checking bench for canny_stream_fuse (DELAY=15)
module tb_canny_stream_fuse;
  localparam int PIX_W  = 16;
  localparam int DELAY  = 15;
  localparam int MODE_W = 3;
`ifdef CANNY_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  logic              video_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              src_hs, src_vs, src_de;
  logic [PIX_W-1:0]  src_data;
  logic              edge_hs, edge_vs, edge_de, edge_bit;
  logic [MODE_W-1:0] mode;
  logic [PIX_W-1:0]  edge_color;
  logic              out_hs, out_vs, out_de;
  logic [PIX_W-1:0]  out_data;
  logic [MODE_W-1:0] active_mode;
  logic              align_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [PIX_W-1:0] exp_d;

  always #5 video_clk = ~video_clk;

  canny_stream_fuse #(.PIX_W(PIX_W), .DELAY(DELAY), .MODE_W(MODE_W)) dut (
    .video_clk(video_clk), .rst_n(rst_n),
    .src_hs(src_hs), .src_vs(src_vs), .src_de(src_de), .src_data(src_data),
    .edge_hs(edge_hs), .edge_vs(edge_vs), .edge_de(edge_de), .edge_bit(edge_bit),
    .mode(mode), .edge_color(edge_color),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .active_mode(active_mode), .align_err(align_err)
  );

  // src_data carries the cycle index since reset release, so a delayed pixel is cyc-1-DELAY after a step.
  task automatic step();
    src_data = PIX_W'(cyc);
    @(posedge video_clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    src_hs = 0; src_vs = 0; src_de = 0; src_data = '0;
    edge_hs = 0; edge_vs = 0; edge_de = 0; edge_bit = 0;
    mode = '0; edge_color = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge video_clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    src_de = 1; src_hs = 1; src_data = 16'hABCD; mode = 3'd2; edge_vs = 1;
    repeat (3) @(posedge video_clk);
    #1;
    compared++; if (out_hs !== 1'b0) begin mismatched++; $display("FAIL reset out_hs: got %b expected 0", out_hs); end
    compared++; if (out_vs !== 1'b0) begin mismatched++; $display("FAIL reset out_vs: got %b expected 0", out_vs); end
    compared++; if (out_de !== 1'b0) begin mismatched++; $display("FAIL reset out_de: got %b expected 0", out_de); end
    compared++; if (out_data !== 16'h0000) begin mismatched++; $display("FAIL reset out_data: got %h expected 0000", out_data); end
    compared++; if (active_mode !== 3'd0) begin mismatched++; $display("FAIL reset active_mode: got %0d expected 0", active_mode); end
    compared++; if (align_err !== 1'b0) begin mismatched++; $display("FAIL reset align_err: got %b expected 0", align_err); end
  endtask

  task automatic test_fill();
    apply_reset();
    edge_vs = 1; edge_de = 1; mode = 3'd2; edge_bit = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      exp_d = (k < DELAY) ? 16'h0000 : PIX_W'(k - DELAY);
      compared++; if (out_data !== exp_d) begin mismatched++; $display("FAIL fill[%0d] out_data: got %h expected %h", k, out_data, exp_d); end
      if (k == 0) begin
        compared++; if (active_mode !== 3'd2) begin mismatched++; $display("FAIL fill active_mode: got %0d expected 2", active_mode); end
      end
    end
  endtask

  task automatic test_overlay();
    edge_vs = 0; edge_de = 0; step();
    edge_vs = 1; mode = 3'd2; edge_color = 16'hFD68; step();
    edge_vs = 0; mode = 3'd0; edge_color = 16'h0000; src_de = 0; step();
    for (int p = 0; p < 20; p++) begin
      edge_de = 1; edge_bit = (p == 10); edge_hs = (p < 2);
      step();
      exp_d = (p == 10) ? 16'hFD68 : PIX_W'(cyc - 1 - DELAY);
      compared++; if (out_data !== exp_d) begin mismatched++; $display("FAIL overlay[%0d] out_data: got %h expected %h", p, out_data, exp_d); end
      compared++; if (out_de !== 1'b1) begin mismatched++; $display("FAIL overlay[%0d] out_de: got %b expected 1", p, out_de); end
      compared++; if (out_hs !== (p < 2)) begin mismatched++; $display("FAIL overlay[%0d] out_hs: got %b expected %b", p, out_hs, (p < 2)); end
    end
    edge_de = 0; edge_bit = 1; edge_hs = 0; step();
    compared++; if (out_data !== 16'h0000) begin mismatched++; $display("FAIL overlay tail out_data: got %h expected 0000", out_data); end
    compared++; if (out_de !== 1'b0) begin mismatched++; $display("FAIL overlay tail out_de: got %b expected 0", out_de); end
  endtask

  task automatic test_frame_latch();
    edge_de = 0; edge_bit = 0; edge_vs = 1; mode = 3'd1; edge_color = 16'h07E0; step();
    compared++; if (active_mode !== 3'd1) begin mismatched++; $display("FAIL latch first active_mode: got %0d expected 1", active_mode); end
    edge_vs = 0; mode = 3'd3; edge_color = 16'h1234;
    for (int p = 0; p < 8; p++) begin
      edge_de = 1; edge_bit = (p % 2 == 1);
      step();
      exp_d = (p % 2 == 1) ? 16'h07E0 : 16'h0000;
      compared++; if (out_data !== exp_d) begin mismatched++; $display("FAIL latch binary[%0d] out_data: got %h expected %h", p, out_data, exp_d); end
    end
    compared++; if (active_mode !== 3'd1) begin mismatched++; $display("FAIL latch midframe active_mode: got %0d expected 1", active_mode); end
    edge_de = 0; edge_bit = 1; step();
    compared++; if (out_data !== 16'h0000) begin mismatched++; $display("FAIL blanking out_data: got %h expected 0000", out_data); end
    edge_vs = 1; edge_bit = 0; step();
    compared++; if (active_mode !== 3'd3) begin mismatched++; $display("FAIL latch second active_mode: got %0d expected 3", active_mode); end
    edge_vs = 0;
    for (int p = 0; p < 6; p++) begin
      edge_de = 1; edge_bit = (p % 2 == 1);
      step();
      exp_d = (p % 2 == 1) ? PIX_W'(cyc - 1 - DELAY) : 16'h0000;
      compared++; if (out_data !== exp_d) begin mismatched++; $display("FAIL latch masked[%0d] out_data: got %h expected %h", p, out_data, exp_d); end
    end
  endtask

  task automatic test_bypass();
    edge_de = 0; edge_bit = 0; edge_vs = 1; mode = 3'd5; step();
    compared++; if (active_mode !== 3'd5) begin mismatched++; $display("FAIL bypass active_mode: got %0d expected 5", active_mode); end
    edge_vs = 0; mode = 3'd1; edge_de = 1; edge_bit = 1; edge_hs = 1;
    for (int p = 0; p < 8; p++) begin
      src_de = (p >= 2 && p < 6); src_hs = (p == 0); src_vs = (p == 1);
      step();
      exp_d = (p >= 2 && p < 6) ? PIX_W'(cyc - 1) : 16'h0000;
      compared++; if (out_data !== exp_d) begin mismatched++; $display("FAIL bypass[%0d] out_data: got %h expected %h", p, out_data, exp_d); end
      compared++; if (out_de !== (p >= 2 && p < 6)) begin mismatched++; $display("FAIL bypass[%0d] out_de: got %b", p, out_de); end
      compared++; if (out_hs !== (p == 0)) begin mismatched++; $display("FAIL bypass[%0d] out_hs: got %b expected %b", p, out_hs, (p == 0)); end
      compared++; if (out_vs !== (p == 1)) begin mismatched++; $display("FAIL bypass[%0d] out_vs: got %b expected %b", p, out_vs, (p == 1)); end
    end
    edge_hs = 0; src_hs = 0; src_vs = 0;
  endtask

  task automatic test_reset_midframe();
    src_de = 1; step();
    #2 rst_n = 1'b0;
    #1;
    compared++; if (out_de !== 1'b0) begin mismatched++; $display("FAIL midreset out_de: got %b expected 0", out_de); end
    compared++; if (out_data !== 16'h0000) begin mismatched++; $display("FAIL midreset out_data: got %h expected 0000", out_data); end
    compared++; if (active_mode !== 3'd0) begin mismatched++; $display("FAIL midreset active_mode: got %0d expected 0", active_mode); end
    clear_inputs();
    @(posedge video_clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    src_de = 1; step(); step();
    compared++; if (out_data !== 16'h0001) begin mismatched++; $display("FAIL midreset bypass out_data: got %h expected 0001", out_data); end
    src_de = 0; edge_vs = 1; edge_de = 1; mode = 3'd2; edge_bit = 0; step();
    compared++; if (active_mode !== 3'd2) begin mismatched++; $display("FAIL midreset active_mode: got %0d expected 2", active_mode); end
    compared++; if (out_data !== 16'h0000) begin mismatched++; $display("FAIL midreset refill out_data: got %h expected 0000", out_data); end
  endtask

  task automatic align_frame(input int lag, output logic err_before, output logic err_at);
    err_before = 1'bx; err_at = 1'bx;
    src_vs = 1; step();
    src_vs = 0; step();
    for (int i = 0; i < lag + 6; i++) begin
      src_de = (i < 4);
      edge_de = (i >= lag && i < lag + 4);
      step();
      if (i == lag - 1) err_before = align_err;
      if (i == lag) err_at = align_err;
    end
  endtask

  task automatic test_align();
    logic eb, ea;
    apply_reset();
    align_frame(DELAY, eb, ea);
    compared++; if (ea !== 1'b0) begin mismatched++; $display("FAIL align good frame align_err: got %b expected 0", ea); end
    align_frame(DELAY + 1, eb, ea);
    compared++; if (eb !== 1'b0) begin mismatched++; $display("FAIL align before rise align_err: got %b expected 0", eb); end
    compared++; if (ea !== ALIGN_ON) begin mismatched++; $display("FAIL align lag16 align_err: got %b expected %b", ea, ALIGN_ON); end
    align_frame(DELAY, eb, ea);
    compared++; if (align_err !== ALIGN_ON) begin mismatched++; $display("FAIL align sticky align_err: got %b expected %b", align_err, ALIGN_ON); end
    rst_n = 1'b0;
    #1;
    compared++; if (align_err !== 1'b0) begin mismatched++; $display("FAIL align cleared align_err: got %b expected 0", align_err); end
    @(posedge video_clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fill();
    test_overlay();
    test_frame_latch();
    test_bypass();
    test_reset_midframe();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
